// File: rtl/daq_run_if.sv
// Command/status bundle between a run sequencer and daq_run_controller.
// master drives commands and reader monitors; slave is the controller side.
interface daq_run_if #(
  parameter int unsigned CNT_W = 32
);
  logic             cmd_start;
  logic             cmd_stop;
  logic [CNT_W-1:0] run_length;
  logic             fifo_prog_full;
  logic             wr_mon;
  logic             start_daq;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] word_count;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] throttle_count;
  logic [2:0]       state_o;

  modport master (
    output cmd_start, cmd_stop, run_length, fifo_prog_full, wr_mon,
    input  start_daq, busy, done, word_count, frame_count, throttle_count, state_o
  );

  modport slave (
    input  cmd_start, cmd_stop, run_length, fifo_prog_full, wr_mon,
    output start_daq, busy, done, word_count, frame_count, throttle_count, state_o
  );
endinterface

// File: rtl/daq_run_controller.sv
// Run sequencer for a latch-reader DAQ: arm, timed/unlimited run, drain, done.
// Define DAQ_RUN_THROTTLE_EN to pause the reader while fifo_prog_full is high.
module daq_run_controller #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned QUIET_CYCLES = 4
) (
  input logic       clk,
  input logic       rst,
  daq_run_if.slave  bus
);
  localparam int unsigned QW = (QUIET_CYCLES < 1) ? 1 : $clog2(QUIET_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_ARM      = 3'b001,
    S_RUN      = 3'b010,
    S_THROTTLE = 3'b011,
    S_DRAIN    = 3'b100,
    S_DONE     = 3'b101
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, len_q;
  logic [CNT_W-1:0] word_q, frame_q, thr_q;
  logic [QW-1:0]    quiet_q, quiet_inc;
  logic             start_daq_q, busy_q, done_q, wr_mon_d;
  logic             expire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign expire    = (len_q != '0) && (timer_q == len_q - CNT_W'(1));
  assign quiet_inc = quiet_q + QW'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state; stop beats expiry, expiry beats throttling
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.cmd_start && !bus.cmd_stop) state_d = S_ARM;
      S_ARM:      state_d = bus.cmd_stop ? S_DRAIN : S_RUN;
      S_RUN: begin
        if (bus.cmd_stop || expire) state_d = S_DRAIN;
`ifdef DAQ_RUN_THROTTLE_EN
        else if (bus.fifo_prog_full) state_d = S_THROTTLE;
`endif
      end
      S_THROTTLE: begin
        if (bus.cmd_stop || expire) state_d = S_DRAIN;
`ifdef DAQ_RUN_THROTTLE_EN
        else if (!bus.fifo_prog_full) state_d = S_RUN;
`else
        else state_d = S_RUN;
`endif
      end
      S_DRAIN:    if (!bus.wr_mon && (quiet_inc >= QW'(QUIET_CYCLES))) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Status outputs registered from next state so they line up with state_o
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_daq_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_mon_d    <= 1'b0;
      quiet_q     <= '0;
    end else begin
      start_daq_q <= (state_d == S_RUN);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      wr_mon_d    <= bus.wr_mon;
      if (state_q == S_DRAIN) quiet_q <= bus.wr_mon ? '0 : quiet_inc;
      else                    quiet_q <= '0;
    end
  end

  // Run timer and statistics; cleared only in ARM, held through IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      len_q   <= '0;
      word_q  <= '0;
      frame_q <= '0;
    end else if (state_q == S_ARM) begin
      timer_q <= '0;
      len_q   <= bus.run_length;
      word_q  <= '0;
      frame_q <= '0;
    end else begin
      if (state_q == S_RUN || state_q == S_THROTTLE) timer_q <= sat_inc(timer_q);
      if (state_q != S_IDLE) begin
        if (bus.wr_mon)              word_q  <= sat_inc(word_q);
        if (bus.wr_mon && !wr_mon_d) frame_q <= sat_inc(frame_q);
      end
    end
  end

`ifdef DAQ_RUN_THROTTLE_EN
  // Counts RUN->THROTTLE entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          thr_q <= '0;
    else if (state_q == S_ARM)                        thr_q <= '0;
    else if (state_q == S_RUN && state_d == S_THROTTLE) thr_q <= sat_inc(thr_q);
  end
`else
  assign thr_q = '0;
`endif

  assign bus.start_daq      = start_daq_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.word_count     = word_q;
  assign bus.frame_count    = frame_q;
  assign bus.throttle_count = thr_q;
  assign bus.state_o        = state_q;
endmodule
